// File: rtl/ldpc_enc_tx_if.sv
// Info-bit input handshake and BPSK symbol output stream of the LDPC encoder.
// Signal names are written from the encoder's point of view.
interface ldpc_enc_tx_if #(
  parameter int WIDTH = 8
);
  logic             i_data;
  logic             i_val;
  logic             o_rdy;
  logic [WIDTH-1:0] o_data;
  logic             o_val;
  logic             o_last;

  modport master (output i_data, i_val, input o_rdy, o_data, o_val, o_last);
  modport slave  (input i_data, i_val, output o_rdy, o_data, o_val, o_last);
endinterface

// File: rtl/ldpc_enc_tx.sv
// Serial systematic LDPC encoder with BPSK mapping: info bits pass through as symbols
// while parity accumulates, then N_CHK parity symbols follow.
module ldpc_enc_tx #(
  parameter int N_BITS = 12,
  parameter int N_CHK  = 6,
  parameter int WIDTH  = 8,
  parameter int AMP    = 4,
  parameter logic [(N_BITS-N_CHK)*N_CHK-1:0] P_MATRIX =
    {6'b011001, 6'b101010, 6'b110100, 6'b001011, 6'b010110, 6'b100101}
) (
  input  logic              clk,
  input  logic              xrst,
  ldpc_enc_tx_if.slave      bus,
  output logic [N_BITS-1:0] o_code,
  output logic [15:0]       o_frames
);

  localparam int K_INFO = N_BITS - N_CHK;
  localparam int CNT_W  = $clog2(N_BITS + 1);
  localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(K_INFO - 1);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(N_CHK - 1);
  localparam logic [WIDTH-1:0] SYM_POS = WIDTH'(AMP);
  localparam logic [WIDTH-1:0] SYM_NEG = WIDTH'(-AMP);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [N_CHK-1:0]    r_par, w_par_nxt;
  logic [K_INFO-1:0]   r_info, w_info_nxt;
  logic [WIDTH-1:0]    r_data, w_data_nxt;
  logic                r_val, w_val_nxt;
  logic                r_last, w_last_nxt;
  logic [N_BITS-1:0]   r_code, w_code_nxt;
  logic [15:0]         r_frames, w_frames_nxt;
  logic [N_CHK-1:0]    w_row;
  logic                w_pbit;
  logic [N_BITS-1:0]   w_code_full;

  always_comb begin
    // NOTE: every value driven here gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_par_nxt    = r_par;
    w_info_nxt   = r_info;
    w_data_nxt   = r_data;
    w_val_nxt    = 1'b0;
    w_last_nxt   = 1'b0;
    w_code_nxt   = r_code;
    w_frames_nxt = r_frames;
    w_row        = '0;
    w_pbit       = 1'b0;
    w_code_full  = '0;

    for (int j = 0; j < K_INFO; j++) begin
      if (r_cnt == CNT_W'(j)) w_row = P_MATRIX[j*N_CHK +: N_CHK];
      w_code_full[N_BITS-1-j] = r_info[j];
    end
    for (int c = 0; c < N_CHK; c++) begin
      if (r_cnt == CNT_W'(c)) w_pbit = r_par[c];
      w_code_full[N_CHK-1-c] = r_par[c];
    end

    unique case (r_state)
      // IDLE always holds r_cnt at zero, so it shares the accept path with DATA.
      S_IDLE, S_DATA: begin
        if (bus.i_val) begin
          for (int j = 0; j < K_INFO; j++)
            if (r_cnt == CNT_W'(j)) w_info_nxt[j] = bus.i_data;
          if (bus.i_data) w_par_nxt = r_par ^ w_row;
          w_data_nxt = bus.i_data ? SYM_NEG : SYM_POS;
          w_val_nxt  = 1'b1;
          if (r_cnt == K_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_PARITY;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = S_DATA;
          end
        end
      end
      S_PARITY: begin
        w_data_nxt = w_pbit ? SYM_NEG : SYM_POS;
        w_val_nxt  = 1'b1;
        if (r_cnt == C_LAST) begin
          w_last_nxt   = 1'b1;
          w_code_nxt   = w_code_full;
          w_frames_nxt = r_frames + 16'd1;
          w_par_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_par    <= '0;
      r_info   <= '0;
      r_data   <= '0;
      r_val    <= 1'b0;
      r_last   <= 1'b0;
      r_code   <= '0;
      r_frames <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_par    <= w_par_nxt;
      r_info   <= w_info_nxt;
      r_data   <= w_data_nxt;
      r_val    <= w_val_nxt;
      r_last   <= w_last_nxt;
      r_code   <= w_code_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  assign bus.o_rdy  = (r_state != S_PARITY);
  assign bus.o_data = r_data;
  assign bus.o_val  = r_val;
  assign bus.o_last = r_last;
  assign o_code     = r_code;
  assign o_frames   = r_frames;

endmodule

// File: tb/tb_ldpc_enc_tx.sv
// Self-checking bench for ldpc_enc_tx: cycle-accurate reference model feeding a symbol
// scoreboard, a table of info words with hand-derived codewords, and corner-case sequences.
module tb_ldpc_enc_tx;

  localparam int N_BITS = 12;
  localparam int N_CHK  = 6;
  localparam int K_INFO = 6;
  localparam int WIDTH  = 8;
  localparam logic [35:0] P_MAT =
    {6'b011001, 6'b101010, 6'b110100, 6'b001011, 6'b010110, 6'b100101};

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } sym_t;

  typedef struct {
    logic [K_INFO-1:0] info;   // info[j] is arrival bit j
    logic [N_BITS-1:0] code;
  } vec_t;

  logic              clk  = 1'b0;
  logic              xrst = 1'b0;
  logic [N_BITS-1:0] o_code;
  logic [15:0]       o_frames;

  ldpc_enc_tx_if #(.WIDTH(WIDTH)) bus ();

  ldpc_enc_tx #(
    .N_BITS(N_BITS), .N_CHK(N_CHK), .WIDTH(WIDTH), .AMP(4), .P_MATRIX(P_MAT)
  ) dut (
    .clk(clk), .xrst(xrst), .bus(bus), .o_code(o_code), .o_frames(o_frames)
  );

  always #5 clk = ~clk;

  sym_t              q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                m_par_left = 0;
  int                m_cnt = 0;
  logic [K_INFO-1:0] m_info = '0;
  logic [N_BITS-1:0] m_code = '0;
  logic [15:0]       m_frames = '0;
  logic              exp_val = 1'b0;
  logic [WIDTH-1:0]  last_data = '0;
  vec_t              tbl[6];

  function automatic logic [WIDTH-1:0] f_sym(input logic b);
    return b ? 8'hFC : 8'h04;
  endfunction

  function automatic logic [N_CHK-1:0] f_parity(input logic [K_INFO-1:0] info);
    logic [N_CHK-1:0] p = '0;
    for (int j = 0; j < K_INFO; j++)
      if (info[j]) p ^= P_MAT[j*N_CHK +: N_CHK];
    return p;
  endfunction

  function automatic logic [N_BITS-1:0] f_code(input logic [K_INFO-1:0] info,
                                               input logic [N_CHK-1:0] par);
    logic [N_BITS-1:0] c = '0;
    for (int j = 0; j < K_INFO; j++) c[N_BITS-1-j] = info[j];
    for (int k = 0; k < N_CHK; k++) c[N_CHK-1-k] = par[k];
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs of the previous edge, drive inputs, advance the model.
  task automatic cycle(input logic v, input logic d);
    sym_t             s;
    logic [N_CHK-1:0] par;
    @(negedge clk);
    check("o_val", bus.o_val, exp_val);
    if (bus.o_val) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_symbol actual=%h required=none at %0t", bus.o_data, $time);
      end else begin
        s = q.pop_front();
        check("o_data", bus.o_data, s.data);
        check("o_last", bus.o_last, s.last);
        last_data = s.data;
      end
    end else begin
      check("o_last_idle", bus.o_last, 1'b0);
      check("o_data_hold", bus.o_data, last_data);
    end

    bus.i_val  = v;
    bus.i_data = d;
    check("o_rdy", bus.o_rdy, m_par_left == 0);
    exp_val = 1'b0;
    if (m_par_left > 0) begin
      exp_val = 1'b1;
      m_par_left--;
    end else if (v) begin
      exp_val = 1'b1;
      m_info[m_cnt] = d;
      q.push_back('{data: f_sym(d), last: 1'b0});
      m_cnt++;
      if (m_cnt == K_INFO) begin
        par = f_parity(m_info);
        for (int c = 0; c < N_CHK; c++)
          q.push_back('{data: f_sym(par[c]), last: (c == N_CHK-1)});
        m_par_left = N_CHK;
        m_cnt      = 0;
        m_code     = f_code(m_info, par);
        m_frames   = m_frames + 16'd1;
      end
    end
  endtask

  task automatic drain();
    int budget = 40;
    while (q.size() > 0 && budget > 0) begin
      cycle(1'b0, 1'b0);
      budget--;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
    check("o_code", o_code, m_code);
    check("o_frames", o_frames, m_frames);
  endtask

  task automatic run_codeword(input logic [K_INFO-1:0] info, input bit gaps);
    for (int j = 0; j < K_INFO; j++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cycle(1'b0, 1'($urandom_range(0, 1)));
      cycle(1'b1, info[j]);
    end
    drain();
  endtask

  task automatic check_syndrome(input logic [N_BITS-1:0] code);
    logic s;
    for (int c = 0; c < N_CHK; c++) begin
      s = code[N_CHK-1-c];
      for (int j = 0; j < K_INFO; j++)
        if (code[N_BITS-1-j]) s ^= P_MAT[j*N_CHK + c];
      check("syndrome", s, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    xrst       = 1'b0;
    bus.i_val  = 1'b0;
    bus.i_data = 1'b0;
    #1;
    check("rst_o_val", bus.o_val, 1'b0);
    check("rst_o_last", bus.o_last, 1'b0);
    check("rst_o_data", bus.o_data, 8'h00);
    check("rst_o_code", o_code, 12'h000);
    check("rst_o_frames", o_frames, 16'h0000);
    check("rst_o_rdy", bus.o_rdy, 1'b1);
    q.delete();
    m_par_left = 0;
    m_cnt      = 0;
    m_info     = '0;
    m_code     = '0;
    m_frames   = '0;
    exp_val    = 1'b0;
    last_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_hold_o_val", bus.o_val, 1'b0);
    xrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bus.i_val  = 1'b0;
    bus.i_data = 1'b0;
    tbl[0] = '{info: 6'b000000, code: 12'h000};
    tbl[1] = '{info: 6'b000001, code: 12'b100000_101001};
    tbl[2] = '{info: 6'b111111, code: 12'hFFF};
    tbl[3] = '{info: 6'b000010, code: 12'h41A};
    tbl[4] = '{info: 6'b100000, code: 12'h066};
    tbl[5] = '{info: 6'b000011, code: 12'hC33};

    // Continuous input, one codeword per table row.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_codeword(tbl[i].info, 1'b0);
      check("tbl_code", o_code, tbl[i].code);
      check_syndrome(o_code);
      if (i == 0) check("frames_first", o_frames, 16'd1);
    end

    // Same words with random i_val gaps inside DATA.
    for (int i = 0; i < 6; i++) begin
      run_codeword(tbl[i].info, 1'b1);
      check("gap_code", o_code, tbl[i].code);
    end

    // Back-to-back codewords with i_val held high through PARITY.
    do_reset();
    for (int j = 0; j < K_INFO; j++) cycle(1'b1, 6'b101101 >> j);
    for (int j = 0; j < N_CHK; j++)  cycle(1'b1, 1'($urandom_range(0, 1)));
    for (int j = 0; j < K_INFO; j++) cycle(1'b1, 6'b010011 >> j);
    drain();
    check("b2b_frames", o_frames, 16'd2);
    check("b2b_code", o_code, f_code(6'b010011, f_parity(6'b010011)));

    // Reset after three info bits, then a clean zero codeword.
    do_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    do_reset();
    run_codeword(6'b000000, 1'b0);
    check("post_rst_frames", o_frames, 16'd1);
    check("post_rst_code", o_code, 12'h000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
